// File: rtl/uart_trx_fifo.sv
// uart_trx_fifo: full-duplex UART (baud timing, TX serialiser, RX deserialiser)
// with a FIFO on each direction and valid/ready streams on the user side.
// Optional parity bit: define UART_PARITY_EN (default build has no parity).

// Circular-buffer FIFO with a combinational head (first-word fall-through).
module uart_trx_fifo_buf #(
  parameter int  W     = 8,
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop && !o_empty;
  // A push into a full buffer is still taken when the head leaves in the same cycle.
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_count = r_count;
  assign o_data  = o_empty ? '0 : r_mem[r_rd];

  // storage write; no reset needed, the head is masked while empty
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  // pointers wrap naturally at DEPTH (power of two); count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module uart_trx_fifo #(
  parameter int  CLK_HZ     = 50000000,
  parameter int  BAUD       = 115200,
  parameter int  DATA_BITS  = 8,
  parameter int  STOP_BITS  = 1,
  parameter int  FIFO_DEPTH = 16,
  parameter int  PARITY_ODD = 0,
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [CW-1:0]        tx_count,
  output logic [CW-1:0]        rx_count,
  output logic                 rx_overrun,
  output logic                 frame_err,
  output logic                 parity_err,
  input  logic                 err_clr
);
  localparam int CPB = CLK_HZ / BAUD;
  localparam int TCW = $clog2(STOP_BITS * CPB + 1);
  localparam int RCW = $clog2(CPB + 1);
  localparam int BW  = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } st_t;

  // ---------------- FIFOs ----------------
  logic [DATA_BITS-1:0] w_tx_head;
  logic                 w_tx_full;
  logic                 w_tx_empty;
  logic                 w_tx_pop;
  logic                 w_rx_full;
  logic                 w_rx_empty;
  logic                 w_rx_push;
  logic [DATA_BITS-1:0] r_rx_shift;

  assign tx_ready = !w_tx_full;
  assign rx_valid = !w_rx_empty;

  uart_trx_fifo_buf #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n),
    .i_push(tx_valid && tx_ready), .i_data(tx_data), .i_pop(w_tx_pop),
    .o_data(w_tx_head), .o_count(tx_count), .o_full(w_tx_full), .o_empty(w_tx_empty)
  );

  uart_trx_fifo_buf #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n),
    .i_push(w_rx_push), .i_data(r_rx_shift), .i_pop(rx_ready),
    .o_data(rx_data), .o_count(rx_count), .o_full(w_rx_full), .o_empty(w_rx_empty)
  );

  // ---------------- TX ----------------
  st_t                  r_tx_state, w_tx_state_n;
  logic [TCW-1:0]       r_tx_cnt, w_tx_cnt_n;
  logic [BW-1:0]        r_tx_bit, w_tx_bit_n;
  logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_n;
  logic                 r_tx, w_tx_line_n;
  logic                 w_tx_load;
`ifdef UART_PARITY_EN
  localparam logic P_ODD = (PARITY_ODD != 0);
  logic                 r_tx_par, w_tx_par_n;
`endif

  assign tx = r_tx;

  // TX state, counters and line register; reset forces the line idle at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_n;
      r_tx_cnt   <= w_tx_cnt_n;
      r_tx_bit   <= w_tx_bit_n;
      r_tx_shift <= w_tx_shift_n;
      r_tx       <= w_tx_line_n;
    end
  end

  // TX next state; the line is derived from the next state so it is registered
  always_comb begin
    w_tx_state_n = r_tx_state;
    w_tx_cnt_n   = r_tx_cnt + 1'b1;
    w_tx_bit_n   = r_tx_bit;
    w_tx_shift_n = r_tx_shift;
    w_tx_load    = 1'b0;
`ifdef UART_PARITY_EN
    w_tx_par_n   = r_tx_par;
`endif
    case (r_tx_state)
      S_IDLE: begin
        w_tx_cnt_n = '0;
        if (!w_tx_empty) w_tx_load = 1'b1;
      end
      S_START: begin
        if (r_tx_cnt == TCW'(CPB - 1)) begin
          w_tx_cnt_n   = '0;
          w_tx_bit_n   = '0;
          w_tx_state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (r_tx_cnt == TCW'(CPB - 1)) begin
          w_tx_cnt_n   = '0;
          w_tx_shift_n = {1'b0, r_tx_shift[DATA_BITS-1:1]};
          if (r_tx_bit == BW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
            w_tx_state_n = S_PARITY;
`else
            w_tx_state_n = S_STOP;
`endif
          end else begin
            w_tx_bit_n = r_tx_bit + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (r_tx_cnt == TCW'(CPB - 1)) begin
          w_tx_cnt_n   = '0;
          w_tx_state_n = S_STOP;
        end
      end
`endif
      S_STOP: begin
        // back-to-back: next byte starts right after the last stop cycle
        if (r_tx_cnt == TCW'(STOP_BITS * CPB - 1)) begin
          w_tx_cnt_n   = '0;
          w_tx_state_n = S_IDLE;
          if (!w_tx_empty) w_tx_load = 1'b1;
        end
      end
      default: begin
        w_tx_cnt_n   = '0;
        w_tx_state_n = S_IDLE;
      end
    endcase
    if (w_tx_load) begin
      w_tx_state_n = S_START;
      w_tx_shift_n = w_tx_head;
`ifdef UART_PARITY_EN
      w_tx_par_n   = (^w_tx_head) ^ P_ODD;
`endif
    end
    case (w_tx_state_n)
      S_START:  w_tx_line_n = 1'b0;
      S_DATA:   w_tx_line_n = w_tx_shift_n[0];
`ifdef UART_PARITY_EN
      S_PARITY: w_tx_line_n = w_tx_par_n;
`endif
      default:  w_tx_line_n = 1'b1;
    endcase
  end

  assign w_tx_pop = w_tx_load;

  // ---------------- RX ----------------
  logic                 r_rx_s1, r_rx_s2, r_rx_prev;
  st_t                  r_rx_state, w_rx_state_n;
  logic [RCW-1:0]       r_rx_cnt, w_rx_cnt_n;
  logic [BW-1:0]        r_rx_bit, w_rx_bit_n;
  logic [DATA_BITS-1:0] w_rx_shift_n;
  logic                 r_rx_brk, w_rx_brk_n;
  logic                 w_ferr_set;
  logic                 w_ovr_set;
  logic                 r_ovr, r_ferr;
`ifdef UART_PARITY_EN
  logic                 r_rx_pbad, w_rx_pbad_n;
  logic                 w_perr_set;
  logic                 r_perr;
`endif

  // two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  // RX state and sample registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_brk   <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_n;
      r_rx_cnt   <= w_rx_cnt_n;
      r_rx_bit   <= w_rx_bit_n;
      r_rx_shift <= w_rx_shift_n;
      r_rx_brk   <= w_rx_brk_n;
    end
  end

  // RX next state; every bit is sampled mid-cell, push happens at mid-stop
  always_comb begin
    w_rx_state_n = r_rx_state;
    w_rx_cnt_n   = r_rx_cnt + 1'b1;
    w_rx_bit_n   = r_rx_bit;
    w_rx_shift_n = r_rx_shift;
    w_rx_brk_n   = r_rx_brk;
    w_rx_push    = 1'b0;
    w_ferr_set   = 1'b0;
`ifdef UART_PARITY_EN
    w_rx_pbad_n  = r_rx_pbad;
    w_perr_set   = 1'b0;
`endif
    case (r_rx_state)
      S_IDLE: begin
        w_rx_cnt_n = '0;
        if (r_rx_prev && !r_rx_s2) w_rx_state_n = S_START;
      end
      S_START: begin
        // a start bit that is high again at half-cell was a glitch
        if (r_rx_cnt == RCW'(CPB / 2 - 1)) begin
          w_rx_cnt_n   = '0;
          w_rx_bit_n   = '0;
          w_rx_state_n = r_rx_s2 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_rx_cnt == RCW'(CPB - 1)) begin
          w_rx_cnt_n   = '0;
          w_rx_shift_n = {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
          if (r_rx_bit == BW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
            w_rx_state_n = S_PARITY;
`else
            w_rx_state_n = S_STOP;
`endif
          end else begin
            w_rx_bit_n = r_rx_bit + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (r_rx_cnt == RCW'(CPB - 1)) begin
          w_rx_cnt_n   = '0;
          w_rx_pbad_n  = r_rx_s2 ^ (^r_rx_shift) ^ P_ODD;
          w_perr_set   = w_rx_pbad_n;
          w_rx_state_n = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (r_rx_brk) begin
          // after a framing error, hold off until the line is idle again
          w_rx_cnt_n = '0;
          if (r_rx_s2) begin
            w_rx_brk_n   = 1'b0;
            w_rx_state_n = S_IDLE;
          end
        end else if (r_rx_cnt == RCW'(CPB - 1)) begin
          w_rx_cnt_n = '0;
          if (r_rx_s2) begin
            w_rx_state_n = S_IDLE;
`ifdef UART_PARITY_EN
            w_rx_push    = !r_rx_pbad;
`else
            w_rx_push    = 1'b1;
`endif
          end else begin
            w_ferr_set = 1'b1;
            w_rx_brk_n = 1'b1;
          end
        end
      end
      default: begin
        w_rx_cnt_n   = '0;
        w_rx_state_n = S_IDLE;
      end
    endcase
  end

  // a frame arriving into a full FIFO is dropped unless the user pops that cycle
  assign w_ovr_set = w_rx_push && w_rx_full && !rx_ready;

  // sticky error flags; a set in the same cycle as err_clr wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_ovr  <= w_ovr_set  || (r_ovr  && !err_clr);
      r_ferr <= w_ferr_set || (r_ferr && !err_clr);
    end
  end

  assign rx_overrun = r_ovr;
  assign frame_err  = r_ferr;

`ifdef UART_PARITY_EN
  // parity registers: TX parity bit, RX mismatch latch and sticky parity flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_par  <= 1'b0;
      r_rx_pbad <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_tx_par  <= w_tx_par_n;
      r_rx_pbad <= w_rx_pbad_n;
      r_perr    <= w_perr_set || (r_perr && !err_clr);
    end
  end

  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_trx_fifo.sv
// Directed bench for uart_trx_fifo at 10 clocks per bit, 8N1 (8E1 with UART_PARITY_EN).
module tb_uart_trx_fifo;
  localparam int CPB = 10;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tx_valid = 1'b0;
  logic       rx_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic       loop_en = 1'b0;
  logic       rx_drv = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       rx, tx, tx_ready, rx_valid, rx_overrun, frame_err, parity_err;
  logic [7:0] rx_data;
  logic [4:0] tx_count, rx_count;

  int n_pass = 0;
  int n_total = 0;

  assign rx = loop_en ? tx : rx_drv;
  always #5 clk = ~clk;

  uart_trx_fifo #(
    .CLK_HZ(50000000), .BAUD(5000000), .DATA_BITS(8),
    .STOP_BITS(1), .FIFO_DEPTH(16), .PARITY_ODD(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_count(tx_count), .rx_count(rx_count),
    .rx_overrun(rx_overrun), .frame_err(frame_err), .parity_err(parity_err),
    .err_clr(err_clr)
  );

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         glitch;
    logic       exp_push;
    logic [7:0] exp_d;
    logic       exp_ferr;
  } rxv_t;

  rxv_t       vec [7];
  logic [7:0] got [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // expected line level in bit cell b of a frame carrying d
  function automatic logic exp_line(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (NB == 11 && b == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic send_rx(input logic [7:0] d, input logic stop);
    rx_drv = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      tick(CPB);
    end
`ifdef UART_PARITY_EN
    rx_drv = ^d;
    tick(CPB);
`endif
    rx_drv = stop;
    tick(CPB);
    rx_drv = 1'b1;
  endtask

`ifdef UART_PARITY_EN
  task automatic send_rx_p(input logic [7:0] d, input logic p);
    rx_drv = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      tick(CPB);
    end
    rx_drv = p;
    tick(CPB);
    rx_drv = 1'b1;
    tick(CPB);
  endtask
`endif

  initial begin
    int bad, ng, c0, gap_bad, rdy_bad;

    //        data   stop glitch push expd   ferr
    vec[0] = '{8'hA5, 1'b1, 0, 1'b1, 8'hA5, 1'b0};
    vec[1] = '{8'h55, 1'b0, 0, 1'b0, 8'h00, 1'b1};
    vec[2] = '{8'h00, 1'b1, 3, 1'b0, 8'h00, 1'b0};
    vec[3] = '{8'h00, 1'b1, 0, 1'b1, 8'h00, 1'b0};
    vec[4] = '{8'hFF, 1'b1, 0, 1'b1, 8'hFF, 1'b0};
    vec[5] = '{8'h00, 1'b1, 4, 1'b0, 8'h00, 1'b0};
    vec[6] = '{8'h80, 1'b1, 0, 1'b1, 8'h80, 1'b0};

    // ---- reset state ----
    #1 rst_n = 1'b0;
    #2;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_counts", 32'({tx_count, rx_count}), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_flags", 32'({rx_overrun, frame_err, parity_err}), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // ---- single-frame TX of 0x61 ----
    tx_data = 8'h61;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    check("t1_count_after_push", 32'(tx_count), 32'd1);
    check("t1_idle_before_pop", 32'(tx), 32'd1);
    tick(1);
    check("t1_count_after_pop", 32'(tx_count), 32'd0);
    for (int b = 0; b < NB; b++) begin
      bad = 0;
      for (int j = 0; j < CPB; j++) begin
        if (tx !== exp_line(8'h61, b)) bad++;
        tick(1);
      end
      check($sformatf("t1_cell%0d_bad_cycles", b), 32'(bad), 32'd0);
    end
    check("t1_idle_after", 32'(tx), 32'd1);
    tick(5);

    // ---- loopback burst 0x00..0x0F ----
    loop_en = 1'b1;
    rx_ready = 1'b1;
    ng = 0; c0 = -1; gap_bad = 0; rdy_bad = 0;
    for (int cyc = 0; cyc < 16 * FRAME + 200; cyc++) begin
      if (tx_ready !== (tx_count != 5'd16)) rdy_bad++;
      if (rx_valid) begin
        if (ng < 16) got[ng] = rx_data;
        ng++;
      end
      if (c0 < 0 && tx == 1'b0) c0 = cyc;
      if (c0 >= 0 && cyc - c0 < 16 * FRAME) begin
        if ((cyc - c0) % FRAME == 0 && tx !== 1'b0) gap_bad++;
        if ((cyc - c0) % FRAME == FRAME - 1 && tx !== 1'b1) gap_bad++;
      end
      if (cyc < 16) begin
        tx_valid = 1'b1;
        tx_data = 8'(cyc);
      end else begin
        tx_valid = 1'b0;
      end
      tick(1);
    end
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    loop_en = 1'b0;
    check("t2_received_count", 32'(ng), 32'd16);
    for (int i = 0; i < 16; i++) check($sformatf("t2_byte%0d", i), 32'(got[i]), 32'(i));
    check("t2_frame_spacing", 32'(gap_bad), 32'd0);
    check("t2_tx_ready_vs_count", 32'(rdy_bad), 32'd0);
    check("t2_no_flags", 32'({rx_overrun, frame_err, parity_err}), 32'd0);
    tick(5);

    // ---- RX vector table: good frames, framing error, glitches ----
    for (int v = 0; v < 7; v++) begin
      if (vec[v].glitch > 0) begin
        rx_drv = 1'b0;
        tick(vec[v].glitch);
        rx_drv = 1'b1;
        tick(30);
      end else begin
        send_rx(vec[v].d, vec[v].stop);
        tick(5);
      end
      check($sformatf("v%0d_rx_count", v), 32'(rx_count), 32'(vec[v].exp_push));
      check($sformatf("v%0d_frame_err", v), 32'(frame_err), 32'(vec[v].exp_ferr));
      if (vec[v].exp_push) check($sformatf("v%0d_rx_data", v), 32'(rx_data), 32'(vec[v].exp_d));
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      check($sformatf("v%0d_cleared", v), 32'({rx_count, frame_err}), 32'd0);
    end

    // ---- RX overrun: 17 frames into a 16-entry FIFO ----
    rx_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      send_rx(8'(8'h30 + i), 1'b1);
      if (i == 15) begin
        tick(3);
        check("t3_full_count", 32'(rx_count), 32'd16);
        check("t3_no_overrun_at_full", 32'(rx_overrun), 32'd0);
      end
    end
    tick(5);
    check("t3_count_after_17", 32'(rx_count), 32'd16);
    check("t3_overrun_set", 32'(rx_overrun), 32'd1);
    rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t3_pop%0d", i), 32'(rx_data), 32'(8'h30 + i));
      tick(1);
    end
    rx_ready = 1'b0;
    check("t3_drained", 32'({rx_valid, rx_count}), 32'd0);
    check("t3_overrun_sticky", 32'(rx_overrun), 32'd1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("t3_overrun_cleared", 32'(rx_overrun), 32'd0);

`ifdef UART_PARITY_EN
    // ---- parity: TX 0x03 carries even parity 0; RX with wrong parity is dropped ----
    tx_data = 8'h03;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tick(96);
    check("t5_tx_parity_bit", 32'(tx), 32'd0);
    tick(30);
    send_rx_p(8'h03, 1'b1);
    tick(5);
    check("t5_parity_err", 32'(parity_err), 32'd1);
    check("t5_byte_dropped", 32'(rx_count), 32'd0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("t5_parity_cleared", 32'(parity_err), 32'd0);
`endif

    // ---- reset in the middle of a TX frame ----
    send_rx(8'h55, 1'b0);
    tick(5);
    send_rx(8'h12, 1'b1);
    tick(5);
    check("t6_pre_frame_err", 32'(frame_err), 32'd1);
    check("t6_pre_rx_count", 32'(rx_count), 32'd1);
    tx_data = 8'hC3;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tick(36);
    check("t6_tx_low_in_data", 32'(tx), 32'd0);
    rst_n = 1'b0;
    #1;
    check("t6_tx_async_high", 32'(tx), 32'd1);
    check("t6_counts_zero", 32'({tx_count, rx_count}), 32'd0);
    check("t6_rx_valid", 32'(rx_valid), 32'd0);
    check("t6_flags_zero", 32'({rx_overrun, frame_err, parity_err}), 32'd0);
    check("t6_tx_ready_in_reset", 32'(tx_ready), 32'd1);
    @(negedge clk);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    loop_en = 1'b1;
    tx_data = 8'h5A;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    for (int i = 0; i < 3 * FRAME && !rx_valid; i++) tick(1);
    check("t6_rx_after_reset", 32'(rx_valid), 32'd1);
    check("t6_data_after_reset", 32'(rx_data), 32'h5A);
    check("t6_no_err_after_reset", 32'(frame_err), 32'd0);
    loop_en = 1'b0;
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check("t6_drained", 32'(rx_count), 32'd0);
    check("parity_flag_final", 32'(parity_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
